// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with registered outputs, synchronous
// flush and a saturating count of entries discarded by flush.
module pipe_skid_reg #(
  parameter int unsigned DATA_W      = 152,
  parameter int unsigned ZERO_BUBBLE = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int unsigned    SUM_W   = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              main_valid;
  logic              skid_valid;
  logic              accept;
  logic              pop;
  logic [1:0]        n_drop;
  logic [SUM_W-1:0]  drop_sum;

  assign main_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign skid_valid = (state_q == ST_FULL);

  // Ready is a function of held state only, so no path from out_ready to in_ready.
  assign in_ready  = rst & ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign pop       = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign drop_cnt  = drop_q;

  // Entries lost to a flush: held ones not popped this cycle plus any same-cycle accept.
  assign n_drop   = {1'b0, main_valid & ~pop} + {1'b0, skid_valid} + {1'b0, accept};
  assign drop_sum = {2'b00, drop_q} + SUM_W'(n_drop);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    drop_d  = drop_q;
    if (flush) begin
      state_d = ST_EMPTY;
      drop_d  = (drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(drop_sum);
      if (ZERO_BUBBLE != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
            if (ZERO_BUBBLE != 0) main_d = '0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
            if (ZERO_BUBBLE != 0) skid_d = '0;
          end
        end
        default: begin
          // Unreachable encoding: holds until the next flush returns it to EMPTY.
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic, checked
// against a queue-based model of a two-deep FIFO with flush and drop counting.
module tb_pipe_skid_reg;

  localparam int unsigned DATA_W = 152;
  localparam int unsigned CNT_W  = 2;
  localparam int          DROP_MAX = 3;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] model_q[$];
  int                model_drop = 0;

  pipe_skid_reg #(.DATA_W(DATA_W), .ZERO_BUBBLE(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return DATA_W'(r);
  endfunction

  // Compare all observable outputs with what the model says the block holds.
  task automatic check_state(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".in_ready"}, DATA_W'(in_ready), DATA_W'(rst && sz < 2));
    chk({tag, ".out_valid"}, DATA_W'(out_valid), DATA_W'(sz > 0));
    chk({tag, ".out_data"}, out_data, (sz > 0) ? model_q[0] : '0);
    chk({tag, ".occupancy"}, DATA_W'(occupancy), DATA_W'(sz));
    chk({tag, ".drop_cnt"}, DATA_W'(drop_cnt), DATA_W'(model_drop));
  endtask

  // One clock: drive inputs, check pre-edge outputs, advance model across the edge.
  task automatic cycle(input string tag, input logic v, input logic [DATA_W-1:0] d,
                       input logic ord, input logic fl, output logic acc);
    logic pp;
    int   n;
    in_valid  = v;
    in_data   = d;
    out_ready = ord;
    flush     = fl;
    #1;
    check_state(tag);
    acc = v && rst && (model_q.size() < 2);
    pp  = (model_q.size() > 0) && ord;
    @(posedge clk);
    #1;
    if (fl) begin
      n = model_q.size() - (pp ? 1 : 0) + (acc ? 1 : 0);
      model_q.delete();
      model_drop = (model_drop + n > DROP_MAX) ? DROP_MAX : model_drop + n;
    end else begin
      if (pp) void'(model_q.pop_front());
      if (acc) model_q.push_back(d);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b1;
    in_data   = rand_data();
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
    model_q.delete();
    model_drop = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_state("reset");
    end
    rst      = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic              acc;
    logic              pend_v;
    logic [DATA_W-1:0] pend_d;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    check_state("por");
    do_reset();

    // Streaming 1..4 with downstream always ready.
    for (int i = 1; i <= 4; i++) cycle("stream", 1'b1, DATA_W'(i), 1'b1, 1'b0, acc);
    chk("stream.last_data", out_data, DATA_W'(4));
    chk("stream.occ", DATA_W'(occupancy), DATA_W'(1));
    cycle("stream_drain", 1'b0, '0, 1'b1, 1'b0, acc);

    // Backpressure: A, B, C with out_ready low; C stays on the bus until taken.
    cycle("bp_a", 1'b1, DATA_W'(16'hAAAA), 1'b0, 1'b0, acc);
    cycle("bp_b", 1'b1, DATA_W'(16'hBBBB), 1'b0, 1'b0, acc);
    chk("bp.full_occ", DATA_W'(occupancy), DATA_W'(2));
    chk("bp.full_ready", DATA_W'(in_ready), DATA_W'(0));
    cycle("bp_c_blocked", 1'b1, DATA_W'(16'hCCCC), 1'b0, 1'b0, acc);
    chk("bp.c_not_taken", DATA_W'(acc), DATA_W'(0));
    chk("bp.head_a", out_data, DATA_W'(16'hAAAA));
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) cycle("bp_c_retry", 1'b1, DATA_W'(16'hCCCC), 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) cycle("bp_drain", 1'b0, '0, 1'b1, 1'b0, acc);
    chk("bp.empty", DATA_W'(occupancy), DATA_W'(0));

    // Flush while FULL discards both entries.
    do_reset();
    cycle("fl_a", 1'b1, DATA_W'(16'hA1), 1'b0, 1'b0, acc);
    cycle("fl_b", 1'b1, DATA_W'(16'hB1), 1'b0, 1'b0, acc);
    cycle("fl_full", 1'b0, '0, 1'b0, 1'b1, acc);
    check_state("fl_after");
    chk("fl.drop2", DATA_W'(drop_cnt), DATA_W'(2));
    chk("fl.data0", out_data, '0);

    // Flush with same-cycle pop of A and accept of B: only B is dropped.
    do_reset();
    cycle("fap_a", 1'b1, DATA_W'(16'hA2), 1'b0, 1'b0, acc);
    cycle("fap_flush", 1'b1, DATA_W'(16'hB2), 1'b1, 1'b1, acc);
    check_state("fap_after");
    chk("fap.drop1", DATA_W'(drop_cnt), DATA_W'(1));
    chk("fap.empty", DATA_W'(out_valid), DATA_W'(0));

    // Saturation of the 2-bit drop counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle("sat_load", 1'b1, rand_data(), 1'b0, 1'b0, acc);
      cycle("sat_flush", 1'b0, '0, 1'b0, 1'b1, acc);
    end
    check_state("sat_after");
    chk("sat.drop3", DATA_W'(drop_cnt), DATA_W'(3));

    // Asynchronous reset between edges while FULL.
    cycle("ar_a", 1'b1, rand_data(), 1'b0, 1'b0, acc);
    cycle("ar_b", 1'b1, rand_data(), 1'b0, 1'b0, acc);
    chk("ar.full", DATA_W'(occupancy), DATA_W'(2));
    in_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    model_q.delete();
    model_drop = 0;
    check_state("ar_async");
    chk("ar.drop0", DATA_W'(drop_cnt), DATA_W'(0));
    do_reset();

    // Random traffic; an offered item is held on the bus until accepted.
    pend_v = 1'b0;
    pend_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend_v = 1'b1;
        pend_d = rand_data();
      end
      cycle("rand", pend_v, pend_d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), acc);
      if (acc) pend_v = 1'b0;
    end
    check_state("rand_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 152: payload width in bits; legal range 1..512.
REQ-002 Parameter ZERO_BUBBLE, default 1: when 1, invalidated entries also clear their payload to 0; when 0, payload is left unchanged.
REQ-003 Parameter CNT_W, default 8: width of the drop counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous pipeline flush, active-high.
REQ-007 in_valid  input  1  upstream presents in_data.
REQ-008 in_ready  output  1  block can accept in_data this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream consumes the entry this cycle.
REQ-012 out_data  output  DATA_W  payload of the head entry.
REQ-013 occupancy  output  2  number of valid entries held, 0..2.
REQ-014 drop_cnt  output  CNT_W  saturating count of valid entries discarded by flush.

Function
REQ-015 Storage: a main register that drives out_data/out_valid, plus one skid register; both registered, with no combinational path from in_data to out_data.
REQ-016 Transfer rules: accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-017 in_ready = rst & ~skid_valid; it depends only on registered state and rst, never on out_ready.
REQ-018 States are EMPTY (occupancy 0), ONE (occupancy 1, main valid), and FULL (occupancy 2, main and skid valid).
REQ-019 EMPTY: on accept, load main and go to ONE; otherwise stay in EMPTY.
REQ-020 ONE:
- accept & pop: main <= in_data, stay in ONE.
- pop only: go to EMPTY.
- accept only: skid <= in_data, go to FULL.
- neither: hold.
REQ-021 FULL: in_ready = 0. On pop: main <= skid, skid invalidated, go to ONE. Otherwise hold.
REQ-022 Latency: accept in cycle N while EMPTY gives out_valid = 1 with that data in cycle N+1.
REQ-023 Sustained throughput is 1 entry/cycle when out_ready stays high.
REQ-024 Ordering is strictly FIFO.
REQ-025 Stability: while out_valid & ~out_ready, out_data and out_valid hold unchanged.
REQ-026 Flush has highest priority. In a flush cycle, both entries are invalid from the next cycle; any accept in that cycle is discarded.
REQ-027 A pop in the flush cycle counts as delivered.
REQ-028 With ZERO_BUBBLE = 1, flush and every invalidation zero the affected payload register.
REQ-029 drop_cnt increments by the number of valid entries discarded by a flush, excluding an entry popped in that cycle and including an entry accepted in that cycle.
REQ-030 drop_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-031 occupancy always equals main_valid + skid_valid.
REQ-032 Combinations that cannot occur (skid valid while main invalid) are unreachable; if forced, they recover to EMPTY on the next flush.

Reset
REQ-033 rst low asynchronously clears, without waiting for clk: out_valid = 0, skid valid = 0, out_data = 0, skid payload = 0, occupancy = 0, drop_cnt = 0.
REQ-034 in_ready = 0 while rst is low; in_valid is ignored during reset.
REQ-035 Reset asserted mid-transfer discards all held entries; drop_cnt is not incremented for them.
REQ-036 The first accept is possible in the first rising edge after rst deasserts.

Verification
REQ-037 Reset then stream: hold rst low 3 cycles; in_valid = 1 with data 1, 2, 3, 4 on consecutive cycles, out_ready = 1 -> out_data 1, 2, 3, 4 on cycles N+1..N+4; occupancy stays 1; in_ready stays 1.
REQ-038 Backpressure:
- Stimulus: out_ready = 0; send A, B, C.
- Response: A in main, B in skid, occupancy = 2, in_ready = 0, C not accepted and held upstream.
- Then out_ready = 1: out_data A, then B, then C; no loss or duplication.
REQ-039 Flush in FULL:
- Stimulus: fill A, B with out_ready = 0, then assert flush with in_valid = 0.
- Response: next cycle out_valid = 0, occupancy = 0, out_data = 0 (ZERO_BUBBLE = 1), drop_cnt = 2.
REQ-040 Flush with simultaneous accept and pop:
- Stimulus: state ONE holding A; in the same cycle pop A, accept B, and assert flush.
- Response: A counts as delivered, B is discarded, drop_cnt += 1, state EMPTY.
REQ-041 Saturation: with CNT_W = 2, perform 5 single-entry flushes -> drop_cnt reads 3 and holds at 3.
REQ-042 Async reset mid-operation: assert rst low between clock edges while FULL -> outputs clear immediately, before the next edge, in_ready = 0, drop_cnt = 0.
